// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending controller: coin codes,
// denominations, FSM states and the greedy change picker.
package vend_pkg;

    localparam logic [1:0] COIN_5  = 2'b00;
    localparam logic [1:0] COIN_10 = 2'b01;
    localparam logic [1:0] COIN_20 = 2'b10;
    localparam logic [1:0] COIN_50 = 2'b11;

    localparam logic [5:0] VAL_5  = 6'd5;
    localparam logic [5:0] VAL_10 = 6'd10;
    localparam logic [5:0] VAL_20 = 6'd20;
    localparam logic [5:0] VAL_50 = 6'd50;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_VEND   = 2'b01,
        ST_CHANGE = 2'b10
    } state_t;

    // value == 0 means no coin fits the remaining amount
    typedef struct packed {
        logic [1:0] code;
        logic [5:0] value;
    } change_pick_t;

    function automatic logic [5:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  coin_value = VAL_5;
            COIN_10: coin_value = VAL_10;
            COIN_20: coin_value = VAL_20;
            COIN_50: coin_value = VAL_50;
            default: coin_value = VAL_5;
        endcase
    endfunction

    // Largest of 20/10/5 not exceeding the amount; 50 is never paid out
    function automatic change_pick_t change_pick(input logic [15:0] amount);
        change_pick_t pick;
        if (amount >= 16'd20) begin
            pick.code  = COIN_20;
            pick.value = VAL_20;
        end else if (amount >= 16'd10) begin
            pick.code  = COIN_10;
            pick.value = VAL_10;
        end else if (amount >= 16'd5) begin
            pick.code  = COIN_5;
            pick.value = VAL_5;
        end else begin
            pick.code  = COIN_5;
            pick.value = 6'd0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/vend_item_table.sv
// Per-item price and stock register file: one combinational read port,
// a stock-decrement port and a write port that overrides the decrement.
module vend_item_table
    import vend_pkg::*;
#(
    parameter int N_ITEMS  = 16,
    parameter int CREDIT_W = 8,
    parameter int STOCK_W  = 4,
    parameter int IW       = $clog2(N_ITEMS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IW-1:0]       rd_addr,
    output logic [CREDIT_W-1:0] rd_price,
    output logic [STOCK_W-1:0]  rd_stock,
    input  logic                dec_en,
    input  logic [IW-1:0]       dec_addr,
    input  logic                wr_en,
    input  logic [IW-1:0]       wr_addr,
    input  logic [CREDIT_W-1:0] wr_price,
    input  logic [STOCK_W-1:0]  wr_stock
);

    logic [CREDIT_W-1:0] price_r [N_ITEMS];
    logic [STOCK_W-1:0]  stock_r [N_ITEMS];

    assign rd_price = price_r[rd_addr];
    assign rd_stock = stock_r[rd_addr];

    // Table update; an empty table makes every item read sold-out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                price_r[i] <= {CREDIT_W{1'b0}};
                stock_r[i] <= {STOCK_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < N_ITEMS; i++) begin
                if (wr_en && (wr_addr == IW'(i))) begin
                    price_r[i] <= wr_price;
                    stock_r[i] <= wr_stock;
                end else if (dec_en && (dec_addr == IW'(i))) begin
                    stock_r[i] <= stock_r[i] - {{(STOCK_W-1){1'b0}}, 1'b1};
                end else begin
                    stock_r[i] <= stock_r[i];
                end
            end
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: credit accumulation, selection check against the
// item table, dispenser handshake and greedy coin-by-coin change return.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter  int N_ITEMS    = 16,
    parameter  int CREDIT_W   = 8,
    parameter  int STOCK_W    = 4,
    parameter  int MAX_CREDIT = 200,
    localparam int IW         = $clog2(N_ITEMS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    output logic                coin_accept,
    output logic                coin_reject,
    input  logic                sel_valid,
    input  logic [IW-1:0]       sel_item,
    input  logic                cancel,
    input  logic                cfg_we,
    input  logic [IW-1:0]       cfg_addr,
    input  logic [CREDIT_W-1:0] cfg_price,
    input  logic [STOCK_W-1:0]  cfg_stock,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend_valid,
    output logic [IW-1:0]       vend_item,
    input  logic                vend_ready,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    input  logic                change_ready,
    output logic                err_soldout,
    output logic                err_funds,
    output logic                busy
);

    localparam logic [CREDIT_W:0] MAX_CREDIT_L = (CREDIT_W+1)'(MAX_CREDIT);

    state_t              state_r, state_nxt;
    logic [CREDIT_W-1:0] credit_r, credit_nxt;
    logic [IW-1:0]       vend_item_r, vend_item_nxt;
    logic                vend_valid_r, vend_valid_nxt;
    logic                change_valid_r, change_valid_nxt;
    logic [1:0]          change_coin_r, change_coin_nxt;
    logic                coin_accept_r, coin_accept_nxt;
    logic                coin_reject_r, coin_reject_nxt;
    logic                err_soldout_r, err_soldout_nxt;
    logic                err_funds_r, err_funds_nxt;
    logic                busy_r;
    logic                dec_en_s;
    logic [CREDIT_W-1:0] rd_price_s;
    logic [STOCK_W-1:0]  rd_stock_s;
    logic [CREDIT_W:0]   coin_sum_s;
    change_pick_t        pick_nxt_s;

    vend_item_table #(
        .N_ITEMS (N_ITEMS),
        .CREDIT_W(CREDIT_W),
        .STOCK_W (STOCK_W),
        .IW      (IW)
    ) u_table (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (sel_item),
        .rd_price(rd_price_s),
        .rd_stock(rd_stock_s),
        .dec_en  (dec_en_s),
        .dec_addr(sel_item),
        .wr_en   (cfg_we),
        .wr_addr (cfg_addr),
        .wr_price(cfg_price),
        .wr_stock(cfg_stock)
    );

    // Next-state, credit and output pulse decode
    always_comb begin
        state_nxt       = state_r;
        credit_nxt      = credit_r;
        vend_item_nxt   = vend_item_r;
        coin_accept_nxt = 1'b0;
        coin_reject_nxt = 1'b0;
        err_soldout_nxt = 1'b0;
        err_funds_nxt   = 1'b0;
        dec_en_s        = 1'b0;
        coin_sum_s      = {1'b0, credit_r} + (CREDIT_W+1)'(coin_value(coin_code));
        case (state_r)
            ST_IDLE: begin
                if (cancel) begin
                    coin_reject_nxt = coin_valid;
                    if (credit_r != {CREDIT_W{1'b0}}) begin
                        state_nxt = ST_CHANGE;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (sel_valid) begin
                    coin_reject_nxt = coin_valid;
                    if (rd_stock_s == {STOCK_W{1'b0}}) begin
                        err_soldout_nxt = 1'b1;
                    end else if (credit_r < rd_price_s) begin
                        err_funds_nxt = 1'b1;
                    end else begin
                        credit_nxt    = credit_r - rd_price_s;
                        dec_en_s      = 1'b1;
                        vend_item_nxt = sel_item;
                        state_nxt     = ST_VEND;
                    end
                end else if (coin_valid) begin
                    if (coin_sum_s <= MAX_CREDIT_L) begin
                        credit_nxt      = coin_sum_s[CREDIT_W-1:0];
                        coin_accept_nxt = 1'b1;
                    end else begin
                        coin_reject_nxt = 1'b1;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_VEND: begin
                coin_reject_nxt = coin_valid;
                if (vend_ready) begin
                    state_nxt = (credit_r != {CREDIT_W{1'b0}}) ? ST_CHANGE : ST_IDLE;
                end else begin
                    state_nxt = ST_VEND;
                end
            end
            ST_CHANGE: begin
                coin_reject_nxt = coin_valid;
                // No coin offered means the 1..4 remainder is forfeited
                if (!change_valid_r) begin
                    credit_nxt = {CREDIT_W{1'b0}};
                    state_nxt  = ST_IDLE;
                end else if (change_ready) begin
                    credit_nxt = credit_r - CREDIT_W'(coin_value(change_coin_r));
                    if (credit_nxt == {CREDIT_W{1'b0}}) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_CHANGE;
                    end
                end else begin
                    state_nxt = ST_CHANGE;
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                credit_nxt = {CREDIT_W{1'b0}};
            end
        endcase
        pick_nxt_s       = change_pick(16'(credit_nxt));
        change_valid_nxt = (state_nxt == ST_CHANGE) && (pick_nxt_s.value != 6'd0);
        change_coin_nxt  = pick_nxt_s.code;
        vend_valid_nxt   = (state_nxt == ST_VEND);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            credit_r       <= {CREDIT_W{1'b0}};
            vend_item_r    <= {IW{1'b0}};
            vend_valid_r   <= 1'b0;
            change_valid_r <= 1'b0;
            change_coin_r  <= 2'b00;
            coin_accept_r  <= 1'b0;
            coin_reject_r  <= 1'b0;
            err_soldout_r  <= 1'b0;
            err_funds_r    <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_nxt;
            credit_r       <= credit_nxt;
            vend_item_r    <= vend_item_nxt;
            vend_valid_r   <= vend_valid_nxt;
            change_valid_r <= change_valid_nxt;
            change_coin_r  <= change_coin_nxt;
            coin_accept_r  <= coin_accept_nxt;
            coin_reject_r  <= coin_reject_nxt;
            err_soldout_r  <= err_soldout_nxt;
            err_funds_r    <= err_funds_nxt;
            busy_r         <= (state_nxt != ST_IDLE);
        end
    end

    assign credit       = credit_r;
    assign vend_valid   = vend_valid_r;
    assign vend_item    = vend_item_r;
    assign change_valid = change_valid_r;
    assign change_coin  = change_coin_r;
    assign coin_accept  = coin_accept_r;
    assign coin_reject  = coin_reject_r;
    assign err_soldout  = err_soldout_r;
    assign err_funds    = err_funds_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl: purchase, ceiling, error, refund, priority
// and reset scenarios with hand-computed expectations.
module tb_vend_ctrl;

    localparam int N_ITEMS  = 16;
    localparam int CREDIT_W = 8;
    localparam int STOCK_W  = 4;
    localparam int IW       = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                coin_valid, coin_accept, coin_reject;
    logic [1:0]          coin_code;
    logic                sel_valid, cancel, cfg_we;
    logic [IW-1:0]       sel_item, cfg_addr, vend_item;
    logic [CREDIT_W-1:0] cfg_price, credit;
    logic [STOCK_W-1:0]  cfg_stock;
    logic                vend_valid, vend_ready;
    logic                change_valid, change_ready;
    logic [1:0]          change_coin;
    logic                err_soldout, err_funds, busy;

    int n_checks = 0;
    int n_errors = 0;
    int coin_n, coin_seq, coin_sum;

    vend_ctrl #(.N_ITEMS(N_ITEMS), .CREDIT_W(CREDIT_W), .STOCK_W(STOCK_W), .MAX_CREDIT(200)) dut (
        .clk(clk), .reset(reset),
        .coin_valid(coin_valid), .coin_code(coin_code),
        .coin_accept(coin_accept), .coin_reject(coin_reject),
        .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_price(cfg_price), .cfg_stock(cfg_stock),
        .credit(credit), .vend_valid(vend_valid), .vend_item(vend_item), .vend_ready(vend_ready),
        .change_valid(change_valid), .change_coin(change_coin), .change_ready(change_ready),
        .err_soldout(err_soldout), .err_funds(err_funds), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int addr, input int price, input int stock);
        cfg_we = 1'b1;
        cfg_addr = IW'(addr);
        cfg_price = CREDIT_W'(price);
        cfg_stock = STOCK_W'(stock);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic put_coin(input logic [1:0] code);
        coin_valid = 1'b1;
        coin_code = code;
        step();
        coin_valid = 1'b0;
    endtask

    task automatic select(input int item);
        sel_valid = 1'b1;
        sel_item = IW'(item);
        step();
        sel_valid = 1'b0;
    endtask

    task automatic press_cancel();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
    endtask

    // Collect change coins until the controller returns to idle
    task automatic drain(input bit toggle);
        coin_n = 0;
        coin_seq = 0;
        coin_sum = 0;
        for (int k = 0; k < 64; k++) begin
            change_ready = toggle ? k[0] : 1'b1;
            if (change_valid && change_ready) begin
                coin_n++;
                coin_seq = (coin_seq << 2) | int'(change_coin);
                case (change_coin)
                    2'b00:   coin_sum += 5;
                    2'b01:   coin_sum += 10;
                    2'b10:   coin_sum += 20;
                    default: coin_sum += 1000;
                endcase
            end
            step();
            if (!busy) break;
        end
        change_ready = 1'b0;
        check_eq("drain_idle", busy, 0);
        check_eq("drain_credit", credit, 0);
    endtask

    initial begin
        reset = 1'b1;
        coin_valid = 1'b0; coin_code = 2'b00; sel_valid = 1'b0; sel_item = '0;
        cancel = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_price = '0; cfg_stock = '0;
        vend_ready = 1'b0; change_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        check_eq("rst_credit", credit, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_vend", {vend_valid, vend_item}, 0);
        check_eq("rst_change", change_valid, 0);
        check_eq("rst_pulses", {coin_accept, coin_reject, err_soldout, err_funds}, 0);

        // Purchase with 5 change, coin during VEND, then buy out the stock
        cfg(3, 25, 2);
        put_coin(2'b10);
        check_eq("t1_acc20", coin_accept, 1);
        check_eq("t1_cr20", credit, 20);
        put_coin(2'b01);
        check_eq("t1_cr30", credit, 30);
        select(3);
        check_eq("t1_vv", vend_valid, 1);
        check_eq("t1_vi", vend_item, 3);
        check_eq("t1_cr5", credit, 5);
        check_eq("t1_busy", busy, 1);
        put_coin(2'b01);
        check_eq("t1_vend_coin_rej", coin_reject, 1);
        check_eq("t1_vend_cr", credit, 5);
        check_eq("t1_vv_held", vend_valid, 1);
        vend_ready = 1'b1;
        step();
        vend_ready = 1'b0;
        check_eq("t1_vv_drop", vend_valid, 0);
        check_eq("t1_chg_v", change_valid, 1);
        check_eq("t1_chg_c", change_coin, 0);
        drain(1'b0);
        check_eq("t1_n", coin_n, 1);
        check_eq("t1_seq", coin_seq, 0);
        put_coin(2'b11);
        select(3);
        check_eq("t1b_cr25", credit, 25);
        check_eq("t1b_vv", vend_valid, 1);
        vend_ready = 1'b1;
        step();
        vend_ready = 1'b0;
        drain(1'b0);
        check_eq("t1b_seq", coin_seq, 8);
        check_eq("t1b_sum", coin_sum, 25);
        select(3);
        check_eq("t1b_soldout", err_soldout, 1);

        // Credit ceiling
        put_coin(2'b11); put_coin(2'b11); put_coin(2'b11);
        put_coin(2'b10); put_coin(2'b10);
        check_eq("t2_cr190", credit, 190);
        put_coin(2'b10);
        check_eq("t2_rej", coin_reject, 1);
        check_eq("t2_noacc", coin_accept, 0);
        check_eq("t2_cr_hold", credit, 190);
        put_coin(2'b01);
        check_eq("t2_acc", coin_accept, 1);
        check_eq("t2_cr200", credit, 200);
        press_cancel();
        drain(1'b0);
        check_eq("t2_n", coin_n, 10);
        check_eq("t2_seq", coin_seq, 32'h000A_AAAA);

        // Sold-out, insufficient funds, zero price
        select(5);
        check_eq("t3_soldout", err_soldout, 1);
        check_eq("t3_nofunds", err_funds, 0);
        cfg(4, 30, 3);
        put_coin(2'b10); put_coin(2'b00);
        select(4);
        check_eq("t3_funds", err_funds, 1);
        check_eq("t3_cr", credit, 25);
        check_eq("t3_novend", vend_valid, 0);
        cfg(6, 0, 1);
        select(6);
        check_eq("t3_free_vv", vend_valid, 1);
        check_eq("t3_free_vi", vend_item, 6);
        check_eq("t3_free_cr", credit, 25);
        vend_ready = 1'b1;
        step();
        vend_ready = 1'b0;
        drain(1'b0);
        check_eq("t3_sum", coin_sum, 25);

        // Refund 85 with the hopper ready every other cycle
        put_coin(2'b11); put_coin(2'b10); put_coin(2'b01); put_coin(2'b00);
        check_eq("t4_cr85", credit, 85);
        press_cancel();
        check_eq("t4_chg_v", change_valid, 1);
        drain(1'b1);
        check_eq("t4_n", coin_n, 5);
        check_eq("t4_seq", coin_seq, 32'h0000_02A8);
        check_eq("t4_sum", coin_sum, 85);

        // Cancel beats selection and coin in the same cycle
        cfg(7, 10, 1);
        put_coin(2'b01); put_coin(2'b00);
        cancel = 1'b1; sel_valid = 1'b1; sel_item = 4'd7; coin_valid = 1'b1; coin_code = 2'b01;
        step();
        cancel = 1'b0; sel_valid = 1'b0; coin_valid = 1'b0;
        check_eq("t5_rej", coin_reject, 1);
        check_eq("t5_noacc", coin_accept, 0);
        check_eq("t5_novend", vend_valid, 0);
        check_eq("t5_cr", credit, 15);
        check_eq("t5_chg", {change_valid, change_coin}, 3'b101);
        drain(1'b0);
        check_eq("t5_seq", coin_seq, 4);

        // Asynchronous reset while returning change
        put_coin(2'b10); put_coin(2'b10);
        press_cancel();
        check_eq("t6_chg_v", change_valid, 1);
        check_eq("t6_cr40", credit, 40);
        reset = 1'b1;
        #2;
        check_eq("t6_rst_cr", credit, 0);
        check_eq("t6_rst_chg", change_valid, 0);
        check_eq("t6_rst_busy", busy, 0);
        step();
        reset = 1'b0;
        step();
        put_coin(2'b11);
        select(7);
        check_eq("t6_soldout7", err_soldout, 1);
        select(4);
        check_eq("t6_soldout4", err_soldout, 1);
        check_eq("t6_cr50", credit, 50);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
